// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcode constants, state/class enums and opcode decoder for control_unit_fsm
//
// Shared by control_unit_fsm. Holds the 6-bit opcode map, the position of the
// ALU operation field inside the opcode, the FSM state encoding and a decode
// function that folds an opcode into an instruction class.

package cu_pkg;

    // Opcode groups selected by opcode[5:3]; low three bits carry op_alu.
    localparam logic [2:0] OPC_GRP_ALU_R = 3'b000;
    localparam logic [2:0] OPC_GRP_ALU_I = 3'b001;

    // Position of the ALU operation field inside the opcode.
    localparam int OP_ALU_MSB = 2;
    localparam int OP_ALU_LSB = 0;

    localparam logic [5:0] OPC_JMP  = 6'b010000;
    localparam logic [5:0] OPC_JZ   = 6'b010001;
    localparam logic [5:0] OPC_JNZ  = 6'b010010;
    localparam logic [5:0] OPC_CALL = 6'b010011;
    localparam logic [5:0] OPC_RET  = 6'b010100;
    localparam logic [5:0] OPC_IN   = 6'b011000;
    localparam logic [5:0] OPC_OUT  = 6'b011001;
    localparam logic [5:0] OPC_NOP  = 6'b111110;
    localparam logic [5:0] OPC_HALT = 6'b111111;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_IO_WAIT = 2'd2,
        ST_HALT    = 2'd3
    } cu_state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_JMP,
        CLS_JZ,
        CLS_JNZ,
        CLS_CALL,
        CLS_RET,
        CLS_IN,
        CLS_OUT,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_t;

    function automatic instr_class_t decode_opcode(input logic [5:0] opc);
        instr_class_t cls;
        cls = CLS_ILLEGAL;
        if (opc[5:3] == OPC_GRP_ALU_R) begin
            cls = CLS_ALU_R;
        end else if (opc[5:3] == OPC_GRP_ALU_I) begin
            cls = CLS_ALU_I;
        end else begin
            case (opc)
                OPC_JMP:  cls = CLS_JMP;
                OPC_JZ:   cls = CLS_JZ;
                OPC_JNZ:  cls = CLS_JNZ;
                OPC_CALL: cls = CLS_CALL;
                OPC_RET:  cls = CLS_RET;
                OPC_IN:   cls = CLS_IN;
                OPC_OUT:  cls = CLS_OUT;
                OPC_NOP:  cls = CLS_NOP;
                OPC_HALT: cls = CLS_HALT;
                default:  cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/control_unit_fsm.sv
// rtl/control_unit_fsm.sv - multi-cycle control unit FSM with return-stack depth tracking and I/O wait
//
// Purpose: sequences FETCH -> EXEC (-> IO_WAIT) -> FETCH per instruction and
// drives the datapath strobes/selects. Tracks call-stack depth inline and
// halts on stack overflow/underflow.
//
// Configuration macro: CU_IO_TIMEOUT_EN - when defined, IO_WAIT is bounded by
// TIMEOUT_CYCLES and an expired wait sets the sticky io_err flag.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   opcode[5:0]  in   instruction[31:26]
//   z            in   registered zero flag
//   io_ready     in   I/O device finished the transfer
//   io_req       out  I/O transfer pending (IO_WAIT)
//   push, pop    out  return-stack strobes
//   oe           out  output enable for OUT
//   s_stack_mux  out  PC source = stack (RET)
//   s_inc        out  PC source = PC+1 (0 selects jump target)
//   s_mux_alu    out  ALU operand B = immediate
//   s_mux_datos  out  register write data = I/O input
//   we3, wez     out  register file / zero flag write enables
//   pc_we        out  PC write enable, once per instruction
//   op_alu[2:0]  out  ALU operation
//   halted       out  FSM is in HALT
//   stack_err    out  sticky stack overflow/underflow
//   io_err       out  sticky I/O timeout

import cu_pkg::*;

module control_unit_fsm #(
    parameter int STACK_DEPTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       io_ready,
    output logic       io_req,
    output logic       push,
    output logic       pop,
    output logic       oe,
    output logic       s_stack_mux,
    output logic       s_inc,
    output logic       s_mux_alu,
    output logic       s_mux_datos,
    output logic       we3,
    output logic       wez,
    output logic       pc_we,
    output logic [2:0] op_alu,
    output logic       halted,
    output logic       stack_err,
    output logic       io_err
);

    localparam int                  DEPTH_W   = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0]  DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0]  DEPTH_ONE = DEPTH_W'(1);

    if (STACK_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("control_unit_fsm: STACK_DEPTH and TIMEOUT_CYCLES must be >= 1");
    end

    cu_state_t          r_state;
    cu_state_t          w_next_state;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_stack_err;
    logic               r_io_out;       // instruction held in IO_WAIT is OUT (else IN)

    instr_class_t       w_cls;
    logic               w_depth_inc;
    logic               w_depth_dec;
    logic               w_set_stack_err;
    logic               w_io_timeout;

    assign w_cls = decode_opcode(opcode);

`ifdef CU_IO_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_io_err;

    // Counts completed IO_WAIT cycles; the cycle where the count reaches
    // TIMEOUT_CYCLES-1 is the last one allowed, and it becomes the exit cycle.
    assign w_io_timeout = (r_state == ST_IO_WAIT) && !io_ready && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
            r_io_err  <= 1'b0;
        end else begin
            if (r_state == ST_IO_WAIT && !io_ready && !w_io_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_io_timeout) begin
                r_io_err <= 1'b1;
            end
        end
    end

    assign io_err = r_io_err;
`else
    assign w_io_timeout = 1'b0;
    assign io_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FETCH;
            r_depth     <= '0;
            r_stack_err <= 1'b0;
            r_io_out    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_depth_inc) begin
                r_depth <= r_depth + DEPTH_ONE;
            end else if (w_depth_dec) begin
                r_depth <= r_depth - DEPTH_ONE;
            end
            if (w_set_stack_err) begin
                r_stack_err <= 1'b1;
            end
            if (r_state == ST_EXEC) begin
                r_io_out <= (w_cls == CLS_OUT);
            end
        end
    end

    assign stack_err = r_stack_err;

    always_comb begin
        w_next_state    = r_state;
        push            = 1'b0;
        pop             = 1'b0;
        oe              = 1'b0;
        io_req          = 1'b0;
        s_stack_mux     = 1'b0;
        s_inc           = 1'b1;
        s_mux_alu       = 1'b0;
        s_mux_datos     = 1'b0;
        we3             = 1'b0;
        wez             = 1'b0;
        pc_we           = 1'b0;
        op_alu          = 3'b000;
        halted          = 1'b0;
        w_depth_inc     = 1'b0;
        w_depth_dec     = 1'b0;
        w_set_stack_err = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_next_state = ST_EXEC;
            end

            ST_EXEC: begin
                w_next_state = ST_FETCH;
                case (w_cls)
                    CLS_ALU_R, CLS_ALU_I: begin
                        op_alu    = opcode[OP_ALU_MSB:OP_ALU_LSB];
                        s_mux_alu = (w_cls == CLS_ALU_I);
                        we3       = 1'b1;
                        wez       = 1'b1;
                        pc_we     = 1'b1;
                    end
                    CLS_JMP: begin
                        s_inc = 1'b0;
                        pc_we = 1'b1;
                    end
                    CLS_JZ: begin
                        s_inc = !z;
                        pc_we = 1'b1;
                    end
                    CLS_JNZ: begin
                        s_inc = z;
                        pc_we = 1'b1;
                    end
                    CLS_CALL: begin
                        if (r_depth == DEPTH_MAX) begin
                            w_set_stack_err = 1'b1;
                            w_next_state    = ST_HALT;
                        end else begin
                            push        = 1'b1;
                            s_inc       = 1'b0;
                            pc_we       = 1'b1;
                            w_depth_inc = 1'b1;
                        end
                    end
                    CLS_RET: begin
                        if (r_depth == '0) begin
                            w_set_stack_err = 1'b1;
                            w_next_state    = ST_HALT;
                        end else begin
                            pop         = 1'b1;
                            s_stack_mux = 1'b1;
                            pc_we       = 1'b1;
                            w_depth_dec = 1'b1;
                        end
                    end
                    CLS_IN, CLS_OUT: begin
                        // Completion (and pc_we) is deferred to the IO_WAIT exit cycle.
                        w_next_state = ST_IO_WAIT;
                    end
                    CLS_HALT: begin
                        pc_we        = 1'b1;
                        w_next_state = ST_HALT;
                    end
                    default: begin
                        // NOP and illegal opcodes just advance the PC.
                        pc_we = 1'b1;
                    end
                endcase
            end

            ST_IO_WAIT: begin
                io_req = 1'b1;
                oe     = r_io_out;
                if (io_ready) begin
                    pc_we        = 1'b1;
                    we3          = !r_io_out;
                    s_mux_datos  = !r_io_out;
                    w_next_state = ST_FETCH;
                end else if (w_io_timeout) begin
                    pc_we        = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb/tb_control_unit_fsm.sv - directed self-checking bench for control_unit_fsm

module tb_control_unit_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       z;
    logic       io_ready;
    logic       io_req;
    logic       push;
    logic       pop;
    logic       oe;
    logic       s_stack_mux;
    logic       s_inc;
    logic       s_mux_alu;
    logic       s_mux_datos;
    logic       we3;
    logic       wez;
    logic       pc_we;
    logic [2:0] op_alu;
    logic       halted;
    logic       stack_err;
    logic       io_err;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit_fsm #(
        .STACK_DEPTH    (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .z           (z),
        .io_ready    (io_ready),
        .io_req      (io_req),
        .push        (push),
        .pop         (pop),
        .oe          (oe),
        .s_stack_mux (s_stack_mux),
        .s_inc       (s_inc),
        .s_mux_alu   (s_mux_alu),
        .s_mux_datos (s_mux_datos),
        .we3         (we3),
        .wez         (wez),
        .pc_we       (pc_we),
        .op_alu      (op_alu),
        .halted      (halted),
        .stack_err   (stack_err),
        .io_err      (io_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle and releases it 1 time unit after the next edge,
    // leaving the DUT in FETCH.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        step();
        reset = 1'b1;
    endtask

    // Runs one I/O instruction starting from FETCH; io_ready rises once
    // n_low IO_WAIT cycles have been seen.
    task automatic run_io(input logic [5:0] op, input int n_low,
                          output int req_cnt, output int oe_cnt, output int we3_cnt,
                          output int datos_cnt, output int datos_last, output int wez_cnt,
                          output int total, output int done);
        req_cnt = 0; oe_cnt = 0; we3_cnt = 0; datos_cnt = 0;
        datos_last = 0; wez_cnt = 0; total = 0; done = 0;
        opcode = op;
        for (int i = 0; i < 30 && done == 0; i++) begin
            io_ready = (req_cnt == n_low);
            #1;
            req_cnt   += int'(io_req);
            oe_cnt    += int'(oe);
            we3_cnt   += int'(we3);
            wez_cnt   += int'(wez);
            if (we3 && s_mux_datos) datos_cnt++;
            if (pc_we) begin
                done       = 1;
                total      = i + 1;
                datos_last = int'(we3 && s_mux_datos);
            end
            step();
        end
        io_ready = 1'b0;
        opcode   = 6'b111110;
    endtask

    int req_cnt, oe_cnt, we3_cnt, datos_cnt, datos_last, wez_cnt, total, done, push_cnt;

    initial begin
        reset    = 1'b0;
        opcode   = 6'b111110;
        z        = 1'b0;
        io_ready = 1'b0;
        #2;
        check_eq("rst_pc_we",     pc_we,     0);
        check_eq("rst_s_inc",     s_inc,     1);
        check_eq("rst_io_req",    io_req,    0);
        check_eq("rst_oe",        oe,        0);
        check_eq("rst_halted",    halted,    0);
        check_eq("rst_stack_err", stack_err, 0);
        check_eq("rst_io_err",    io_err,    0);
        step();
        reset = 1'b1;

        // ALU immediate 001010 then a NOP two cycles later.
        check_eq("fetch_pc_we", pc_we, 0);
        opcode = 6'b001010;
        step();
        check_eq("alui_we3",    we3,       1);
        check_eq("alui_wez",    wez,       1);
        check_eq("alui_mux",    s_mux_alu, 1);
        check_eq("alui_op",     op_alu,    3'b010);
        check_eq("alui_pc_we",  pc_we,     1);
        opcode = 6'b111110;
        step();
        check_eq("next_fetch_pc_we", pc_we, 0);
        step();
        check_eq("next_exec_pc_we", pc_we, 1);
        check_eq("nop_we3",         we3,   0);
        step();

        // ALU register op.
        opcode = 6'b000101;
        step();
        check_eq("alur_we3", we3,       1);
        check_eq("alur_mux", s_mux_alu, 0);
        check_eq("alur_op",  op_alu,    3'b101);
        step();

        // Branches.
        opcode = 6'b010001; z = 1'b0; step();
        check_eq("jz_z0_s_inc", s_inc, 1);
        check_eq("jz_z0_pc_we", pc_we, 1);
        step();
        opcode = 6'b010001; z = 1'b1; step();
        check_eq("jz_z1_s_inc", s_inc, 0);
        step();
        opcode = 6'b010010; z = 1'b1; step();
        check_eq("jnz_z1_s_inc", s_inc, 1);
        step();
        opcode = 6'b010010; z = 1'b0; step();
        check_eq("jnz_z0_s_inc", s_inc, 0);
        step();
        opcode = 6'b010000; step();
        check_eq("jmp_s_inc", s_inc, 0);
        step();

        // Illegal opcode behaves as NOP with no flag.
        opcode = 6'b100000; step();
        check_eq("ill_pc_we", pc_we, 1);
        check_eq("ill_we3",   we3,   0);
        check_eq("ill_s_inc", s_inc, 1);
        step();
        check_eq("ill_stack_err", stack_err, 0);
        check_eq("ill_io_err",    io_err,    0);
        check_eq("ill_halted",    halted,    0);

        // RET at depth 0 underflows.
        opcode = 6'b010100; step();
        check_eq("ret0_pop",   pop,   0);
        check_eq("ret0_pc_we", pc_we, 0);
        step();
        check_eq("ret0_stack_err", stack_err, 1);
        check_eq("ret0_halted",    halted,    1);
        opcode = 6'b111110; step(); step();
        check_eq("halt_stays", halted, 1);
        check_eq("halt_pc_we", pc_we,  0);

        pulse_reset();
        check_eq("rst2_stack_err", stack_err, 0);
        check_eq("rst2_halted",    halted,    0);

        // CALL then RET.
        opcode = 6'b010011; step();
        check_eq("call_push",  push,  1);
        check_eq("call_s_inc", s_inc, 0);
        step();
        opcode = 6'b010100; step();
        check_eq("ret_pop",   pop,         1);
        check_eq("ret_smux",  s_stack_mux, 1);
        check_eq("ret_pc_we", pc_we,       1);
        step();

        // Fill the stack, then overflow.
        push_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            opcode = 6'b010011; step();
            push_cnt += int'(push);
            step();
        end
        check_eq("call16_pushes",    push_cnt,  16);
        check_eq("call16_stack_err", stack_err, 0);
        check_eq("call16_halted",    halted,    0);
        opcode = 6'b010011; step();
        check_eq("call17_push",   push,   0);
        check_eq("call17_pc_we",  pc_we,  0);
        step();
        check_eq("call17_stack_err", stack_err, 1);
        check_eq("call17_halted",    halted,    1);

        pulse_reset();

        // IN with io_ready low for 4 IO_WAIT cycles.
        run_io(6'b011000, 4, req_cnt, oe_cnt, we3_cnt, datos_cnt, datos_last, wez_cnt, total, done);
        check_eq("in_done",       done,       1);
        check_eq("in_io_req",     req_cnt,    5);
        check_eq("in_datos",      datos_cnt,  1);
        check_eq("in_datos_last", datos_last, 1);
        check_eq("in_we3",        we3_cnt,    1);
        check_eq("in_wez",        wez_cnt,    0);
        check_eq("in_oe",         oe_cnt,     0);
        check_eq("in_total",      total,      7);

`ifdef CU_IO_TIMEOUT_EN
        // OUT with io_ready stuck low times out after 8 IO_WAIT cycles.
        run_io(6'b011001, 1000, req_cnt, oe_cnt, we3_cnt, datos_cnt, datos_last, wez_cnt, total, done);
        check_eq("tmo_done",   done,    1);
        check_eq("tmo_io_req", req_cnt, 8);
        check_eq("tmo_oe",     oe_cnt,  8);
        check_eq("tmo_we3",    we3_cnt, 0);
        check_eq("tmo_total",  total,   10);
        check_eq("tmo_io_err", io_err,  1);
`else
        run_io(6'b011001, 2, req_cnt, oe_cnt, we3_cnt, datos_cnt, datos_last, wez_cnt, total, done);
        check_eq("out_done",   done,    1);
        check_eq("out_io_req", req_cnt, 3);
        check_eq("out_oe",     oe_cnt,  3);
        check_eq("out_we3",    we3_cnt, 0);
        check_eq("out_total",  total,   5);
        check_eq("out_io_err", io_err,  0);
`endif

        // Reset in the 2nd IO_WAIT cycle of an OUT.
        opcode = 6'b011001; io_ready = 1'b0;
        step(); step(); step();
        check_eq("iow2_io_req", io_req, 1);
        check_eq("iow2_oe",     oe,     1);
        reset = 1'b0;
        #1;
        check_eq("arst_io_req", io_req, 0);
        check_eq("arst_oe",     oe,     0);
        check_eq("arst_pc_we",  pc_we,  0);
        step();
        reset  = 1'b1;
        opcode = 6'b111110;
        #1;
        check_eq("rel_pc_we",     pc_we,     0);
        check_eq("rel_halted",    halted,    0);
        check_eq("rel_stack_err", stack_err, 0);
        check_eq("rel_io_err",    io_err,    0);
        step();
        check_eq("rel_exec_pc_we", pc_we, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
